// File: rtl/add_accum_unit.sv
`default_nettype none
// ============================================================================
// Module   : add_accum_unit
// Brief    : Handshaked add/accumulate unit with optional saturation and an
//            output result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module add_accum_unit #(
    parameter int W     = 3,
    parameter int ACC_W = 4,
    parameter int SAT   = 0,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_x,
    input  logic [W-1:0]               in_y,
    input  logic                       in_mode,
    input  logic                       clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_z,
    output logic                       out_ovf,
    output logic [15:0]                count,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH) + 1;

    logic [ACC_W-1:0] r_mem_z [DEPTH];
    logic [DEPTH-1:0] r_mem_ovf;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic [ACC_W-1:0] r_acc;
    logic [15:0]      r_count;

    logic             w_push;
    logic             w_pop;
    logic [W:0]       w_sum;
    logic [ACC_W:0]   w_sum_ext;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W:0]   w_t;
    logic [ACC_W-1:0] w_res;
    logic             w_ovf;

    // No pass-through when full: a same-cycle pop does not open the input.
    assign in_ready  = !rst && (r_level != c_LW'(DEPTH));
    assign w_push    = in_valid && in_ready;
    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready;

    assign w_sum     = {1'b0, in_x} + {1'b0, in_y};
    assign w_sum_ext = {{(ACC_W - W){1'b0}}, w_sum};
    assign w_base    = clr ? '0 : r_acc;
    assign w_t       = {1'b0, w_base} + w_sum_ext;

    always_comb begin
        w_res = w_sum_ext[ACC_W-1:0];
        w_ovf = 1'b0;
        if (in_mode) begin
            w_res = w_t[ACC_W-1:0];
            if (w_t[ACC_W]) begin
                w_ovf = 1'b1;
                if (SAT != 0) begin
                    w_res = '1;
                end
            end
        end
    end

    // Storage is not reset; the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_z[r_wr_ptr]   <= w_res;
            r_mem_ovf[r_wr_ptr] <= w_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_push && in_mode) begin
                r_acc <= w_res;
            end else if (clr) begin
                r_acc <= '0;
            end
        end
    end

    assign out_z   = out_valid ? r_mem_z[r_rd_ptr] : '0;
    assign out_ovf = out_valid ? r_mem_ovf[r_rd_ptr] : 1'b0;
    assign count   = r_count;
    assign level   = r_level;

endmodule
`default_nettype wire

// File: tb/tb_add_accum_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_accum_unit
// Brief    : Scoreboard bench for add_accum_unit; wrap and saturate instances
//            share one stimulus stream and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_accum_unit;

    localparam int W     = 3;
    localparam int ACC_W = 4;
    localparam int DEPTH = 4;
    localparam int MAXV  = (1 << ACC_W) - 1;

    typedef struct packed {
        logic [ACC_W-1:0] z;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_y;
    logic             in_mode;
    logic             clr;
    logic             out_ready;

    logic             in_ready_w, in_ready_s;
    logic             out_valid_w, out_valid_s;
    logic [ACC_W-1:0] out_z_w, out_z_s;
    logic             out_ovf_w, out_ovf_s;
    logic [15:0]      count_w, count_s;
    logic [2:0]       level_w, level_s;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q_w[$];
    exp_t q_s[$];
    int   acc_w    = 0;
    int   acc_s    = 0;
    int   exp_cnt  = 0;

    always #5 clk = ~clk;

    add_accum_unit #(.W(W), .ACC_W(ACC_W), .SAT(0), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .clr(clr),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_z(out_z_w),
        .out_ovf(out_ovf_w), .count(count_w), .level(level_w)
    );

    add_accum_unit #(.W(W), .ACC_W(ACC_W), .SAT(1), .DEPTH(DEPTH)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .clr(clr),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_z(out_z_s),
        .out_ovf(out_ovf_s), .count(count_s), .level(level_s)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference arithmetic: plain integer sums against the result range.
    function automatic exp_t model(input int x, input int y, input bit mode,
                                   input bit c, input bit sat, inout int acc);
        exp_t e;
        int   t;
        if (!mode) begin
            e.z   = ACC_W'(x + y);
            e.ovf = 1'b0;
            if (c) acc = 0;
        end else begin
            t = (c ? 0 : acc) + x + y;
            if (t > MAXV) begin
                e.ovf = 1'b1;
                e.z   = sat ? ACC_W'(MAXV) : ACC_W'(t % (MAXV + 1));
            end else begin
                e.ovf = 1'b0;
                e.z   = ACC_W'(t);
            end
            acc = int'(e.z);
        end
        return e;
    endfunction

    // Monitor + scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        bit   rdy;
        exp_t e;
        if (rst) begin
            q_w.delete();
            q_s.delete();
            acc_w   = 0;
            acc_s   = 0;
            exp_cnt = 0;
            check("rst_in_ready", int'(in_ready_w), 0);
            check("rst_out_valid", int'(out_valid_w) + int'(out_valid_s), 0);
            check("rst_level", int'(level_w) + int'(level_s), 0);
            check("rst_count", int'(count_w) + int'(count_s), 0);
            check("rst_out_z", int'(out_z_w) + int'(out_ovf_w), 0);
        end else begin
            rdy = (q_w.size() != DEPTH);
            check("in_ready_wrap", int'(in_ready_w), int'(rdy));
            check("in_ready_sat", int'(in_ready_s), int'(rdy));
            check("level_wrap", int'(level_w), q_w.size());
            check("level_sat", int'(level_s), q_s.size());
            check("count", int'(count_w), exp_cnt & 16'hFFFF);
            check("out_valid_wrap", int'(out_valid_w), int'(q_w.size() != 0));
            check("out_valid_sat", int'(out_valid_s), int'(q_s.size() != 0));
            if (q_w.size() != 0) begin
                check("z_wrap", int'(out_z_w), int'(q_w[0].z));
                check("ovf_wrap", int'(out_ovf_w), int'(q_w[0].ovf));
                if (out_ready) void'(q_w.pop_front());
            end else begin
                check("empty_z_wrap", int'(out_z_w) + int'(out_ovf_w), 0);
            end
            if (q_s.size() != 0) begin
                check("z_sat", int'(out_z_s), int'(q_s[0].z));
                check("ovf_sat", int'(out_ovf_s), int'(q_s[0].ovf));
                if (out_ready) void'(q_s.pop_front());
            end
            if (in_valid && rdy) begin
                e = model(int'(in_x), int'(in_y), in_mode, clr, 1'b0, acc_w);
                q_w.push_back(e);
                e = model(int'(in_x), int'(in_y), in_mode, clr, 1'b1, acc_s);
                q_s.push_back(e);
                exp_cnt++;
            end else if (clr) begin
                acc_w = 0;
                acc_s = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready_w;
            cyc();
        end
        if (!ok) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic send(input int x, input int y, input bit mode, input bit c);
        in_valid = 1'b1;
        in_x     = W'(x);
        in_y     = W'(y);
        in_mode  = mode;
        clr      = c;
        wait_accept();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        clr       = 1'b0;
        for (int i = 0; i < 20 && q_w.size() != 0; i++) cyc();
        if (q_w.size() != 0) check("drain_timeout", q_w.size(), 0);
        cyc();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
        in_mode = 1'b0; clr = 1'b0; out_ready = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Plain adds
        send(5, 5, 1'b0, 1'b0);
        send(7, 7, 1'b0, 1'b0);
        drain();

        // Accumulate into overflow: 12, then 4 (wrap) / 15 (sat)
        send(6, 6, 1'b1, 1'b0);
        send(4, 4, 1'b1, 1'b0);
        drain();
        check("acc_wrap_after_ovf", acc_w, 4);
        check("acc_sat_after_ovf", acc_s, 15);

        // Fill the FIFO with the consumer stalled, hold the fifth pair
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(k, k, 1'b0, 1'b0);
        in_valid = 1'b1; in_x = 3'd5; in_y = 3'd5; in_mode = 1'b0;
        repeat (3) cyc();
        check("full_level", int'(level_w), DEPTH);
        out_ready = 1'b1;
        wait_accept();
        drain();

        // clr alongside an accumulate accept
        in_valid = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
        send(3, 3, 1'b1, 1'b0);
        send(2, 2, 1'b1, 1'b1);
        drain();

        // Asynchronous reset with entries queued
        out_ready = 1'b0;
        send(1, 1, 1'b0, 1'b0);
        send(2, 3, 1'b1, 1'b0);
        send(3, 3, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", int'(out_valid_w), 0);
        check("async_rst_level", int'(level_w), 0);
        repeat (2) cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        cyc();
        send(1, 2, 1'b1, 1'b0);
        drain();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_x      = W'($urandom_range(0, 7));
            in_y      = W'($urandom_range(0, 7));
            in_mode   = $urandom_range(0, 1) != 0;
            clr       = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
